ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Multi-cycle instruction sequencer for the 16-bit datapath. It fetches one instruction word and decodes the opcode, register indices and immediate. It then steps through execute, memory and writeback states. It drives the `op_code`/`imm_en` select lines and `imm_out` value consumed by `data_mux`, plus the register-file write strobe and the memory strobes.

## Interface
Parameters:
- `PC_WIDTH`, 8, width of program counter / instruction address
- `DATA_WIDTH`, 16, instruction and immediate width

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_req`  out  1  instruction fetch request
- `instr_addr`  out  PC_WIDTH  fetch address (= pc)
- `instr_data`  in  DATA_WIDTH  instruction word
- `instr_valid`  in  1  instr_data valid this cycle
- `op_code`  out  4  decoded opcode, to data_mux/ALU
- `imm_en`  out  1  immediate select, to data_mux
- `imm_out`  out  DATA_WIDTH  zero-extended instr[7:0]
- `rd_addr`  out  4  destination register, instr[11:8]
- `rs1_addr`  out  4  source register 1, instr[7:4]
- `rs2_addr`  out  4  source register 2, instr[3:0]
- `reg_we`  out  1  register-file write strobe
- `mem_rd`  out  1  data-memory read strobe
- `mem_wr`  out  1  data-memory write strobe
- `mem_ready`  in  1  data-memory access complete
- `halted`  out  1  high in HALT state

## Operation
Instruction format:
- bits [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
- The immediate is instr[7:0].

Opcodes:
- 0–7: ALU ops.
- 8: LDI, `imm_en`=1.
- 9: LOAD.
- 10: STORE.
- 12: JMP, target instr[7:0].
- 15: HALT.
- 11, 13, 14: NOP.

States:
- FETCH: `instr_req`=1. On `instr_valid`=1 the word is latched into `ir`, pc <= pc+1 (wraps modulo 2^PC_WIDTH), go to DECODE. Otherwise stay.
- DECODE: register `op_code`, `imm_en`, `imm_out`, `rd_addr`/`rs1_addr`/`rs2_addr` from `ir`. Go to EXEC.
- EXEC:
  - ALU/LDI → WB.
  - LOAD/STORE → MEM.
  - JMP: pc <= ir[7:0] (zero-extended/truncated to PC_WIDTH), then → FETCH.
  - NOP → FETCH.
  - HALT → HALT.
- MEM:
  - LOAD holds `mem_rd`=1; STORE holds `mem_wr`=1, until `mem_ready`=1.
  - Then LOAD → WB, STORE → FETCH.
- WB: `reg_we`=1 for exactly one cycle, then → FETCH.
- HALT: absorbing. Only `rst` exits. `halted`=1, all strobes 0.

Decoded outputs:
- Stable from the cycle after DECODE until the next DECODE.
- `data_mux` therefore sees a constant select throughout WB.

## Timing
- Reset (`rst`=1 at an edge):
  - state=FETCH, pc=0, ir=0.
  - `op_code`=0, `imm_en`=0, `imm_out`=0, all register addresses 0.
  - `reg_we`/`mem_rd`/`mem_wr`/`halted`=0.
  - `instr_req`=0 while `rst` high; `instr_req`=1 in the first cycle after `rst` falls.
- Strobes are Moore outputs of the state register, with no combinational path from `instr_valid`/`mem_ready`.
- Latency with zero-wait memories (valid/ready high in the first request cycle):
  - ALU/LDI: 4 cycles (F, D, E, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - JMP/NOP: 3 cycles.
- Each wait cycle on `instr_valid` or `mem_ready` adds exactly one cycle.
- `instr_valid` outside FETCH is ignored. `mem_ready` outside MEM is ignored.
- `rst` asserted in any state, including mid-MEM or HALT, takes priority. The next state is FETCH with pc=0, and no strobe is asserted in the cycle after.
- pc=2^PC_WIDTH−1 fetch wraps to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (OP_LDI=8, OP_LOAD=9, OP_STORE=10, OP_JMP=12, OP_HALT=15);
  - the state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - the instruction field bit positions.
- `data_mux` and the ALU import the same opcodes.
- One natural sub-module: `instr_decode`. It is combinational, maps `ir` to opcode class, fields and immediate, and is registered in `ctrl_fsm`.

## Test plan
- Reset then ALU word 0x1234 with `instr_valid` tied high:
  - `op_code`=1, `rd_addr`=2, `rs1_addr`=3, `rs2_addr`=4.
  - `reg_we` high exactly at cycle 4; pc=1.
- LDI 0x85A7:
  - `imm_en`=1, `imm_out`=0x00A7, `rd_addr`=5.
  - `imm_en` is stable through WB.
- LOAD 0x9310 with `mem_ready` delayed 3 cycles:
  - `mem_rd` high for 4 cycles, then one `reg_we`.
  - Total 8 cycles.
- STORE 0xA012 then JMP 0xC0F0:
  - One `mem_wr` pulse and no `reg_we`.
  - Next `instr_addr`=0xF0.
- HALT 0xF000:
  - `halted`=1 and `instr_req`=0 indefinitely.
  - `rst` pulse → `instr_addr`=0 and `instr_req`=1 in the cycle after `rst` falls.
- Assert `rst` during MEM with `mem_rd` high:
  - The next cycle has all strobes 0, state FETCH, pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit datapath: opcodes, instruction field
// positions, sequencer state encoding and the opcode classifier used by
// ctrl_fsm, data_mux and the ALU.
package cpu_pkg;

  // Opcode values with special meaning; 0..7 are ALU operations and
  // 11, 13, 14 are treated as NOP.
  localparam logic [3:0] OP_LDI   = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;
  localparam logic [3:0] OP_JMP   = 4'd12;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // Instruction field bit positions.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Opcode class: what the sequencer does with an instruction in EXEC.
  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LDI   = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_JMP   = 3'd4,
    CLS_NOP   = 3'd5,
    CLS_HALT  = 3'd6
  } op_class_t;

  // Map a 4-bit opcode onto its execution class.
  function automatic op_class_t op_class(input logic [3:0] op);
    op_class_t cls;
    if (!op[3]) begin
      cls = CLS_ALU;
    end else begin
      case (op)
        OP_LDI:   cls = CLS_LDI;
        OP_LOAD:  cls = CLS_LOAD;
        OP_STORE: cls = CLS_STORE;
        OP_JMP:   cls = CLS_JMP;
        OP_HALT:  cls = CLS_HALT;
        default:  cls = CLS_NOP;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Sequencer-side bus: instruction fetch, decoded select lines toward
// data_mux/ALU, register-file write strobe and data-memory strobes.
// master = ctrl_fsm, slave = surrounding datapath/memories.
interface ctrl_fsm_if #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16
);

  logic                  instr_req;
  logic [PC_WIDTH-1:0]   instr_addr;
  logic [DATA_WIDTH-1:0] instr_data;
  logic                  instr_valid;

  logic [3:0]            op_code;
  logic                  imm_en;
  logic [DATA_WIDTH-1:0] imm_out;
  logic [3:0]            rd_addr;
  logic [3:0]            rs1_addr;
  logic [3:0]            rs2_addr;

  logic                  reg_we;
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  mem_ready;
  logic                  halted;

  modport master (
    output instr_req, instr_addr,
    input  instr_data, instr_valid,
    output op_code, imm_en, imm_out, rd_addr, rs1_addr, rs2_addr,
    output reg_we, mem_rd, mem_wr,
    input  mem_ready,
    output halted
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_data, instr_valid,
    input  op_code, imm_en, imm_out, rd_addr, rs1_addr, rs2_addr,
    input  reg_we, mem_rd, mem_wr,
    output mem_ready,
    input  halted
  );

endinterface

// File: rtl/ctrl_fsm_instr_decode.sv
// Combinational instruction decoder: splits the instruction register into
// opcode, class, register indices and zero-extended immediate. The results
// are registered by ctrl_fsm in DECODE.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] ir,
  output logic [3:0]            op,
  output op_class_t             cls,
  output logic                  imm_en,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [3:0]            rd,
  output logic [3:0]            rs1,
  output logic [3:0]            rs2
);

  // Field extraction and classification.
  always_comb begin
    op     = ir[OPC_MSB:OPC_LSB];
    cls    = op_class(ir[OPC_MSB:OPC_LSB]);
    imm_en = (ir[OPC_MSB:OPC_LSB] == OP_LDI);
    imm    = DATA_WIDTH'(ir[IMM_MSB:IMM_LSB]);
    rd     = ir[RD_MSB:RD_LSB];
    rs1    = ir[RS1_MSB:RS1_LSB];
    rs2    = ir[RS2_MSB:RS2_LSB];
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] ->
// [WB] -> FETCH, with an absorbing HALT. All strobes and decoded select
// lines are registered; only instr_req is additionally masked by rst so it
// stays low while reset is held and rises in the first cycle after release.
//
//   state  | meaning
//   FETCH  | request instr at pc, latch into ir on instr_valid, pc+1
//   DECODE | register op_code/imm/register indices from ir
//   EXEC   | dispatch on opcode class; JMP loads pc here
//   MEM    | hold mem_rd (LOAD) or mem_wr (STORE) until mem_ready
//   WB     | single-cycle reg_we
//   HALT   | absorbing, only rst leaves
module ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  ctrl_fsm_if.master    bus
);

  state_t                state;
  logic [PC_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0] ir;

  logic                  req_q;
  logic [3:0]            op_code_q;
  logic                  imm_en_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [3:0]            rd_q;
  logic [3:0]            rs1_q;
  logic [3:0]            rs2_q;
  logic                  reg_we_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic                  halted_q;

  logic [3:0]            dec_op;
  op_class_t             dec_cls;
  logic                  dec_imm_en;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic [3:0]            dec_rd;
  logic [3:0]            dec_rs1;
  logic [3:0]            dec_rs2;

  instr_decode #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_decode (
    .ir     (ir),
    .op     (dec_op),
    .cls    (dec_cls),
    .imm_en (dec_imm_en),
    .imm    (dec_imm),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2)
  );

  // Sequencer state, pc/ir and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      req_q     <= 1'b1;
      op_code_q <= '0;
      imm_en_q  <= 1'b0;
      imm_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      reg_we_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr_data;
            pc    <= pc + PC_WIDTH'(1);
            req_q <= 1'b0;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          op_code_q <= dec_op;
          imm_en_q  <= dec_imm_en;
          imm_q     <= dec_imm;
          rd_q      <= dec_rd;
          rs1_q     <= dec_rs1;
          rs2_q     <= dec_rs2;
          state     <= S_EXEC;
        end

        S_EXEC: begin
          case (dec_cls)
            CLS_ALU, CLS_LDI: begin
              reg_we_q <= 1'b1;
              state    <= S_WB;
            end
            CLS_LOAD: begin
              mem_rd_q <= 1'b1;
              state    <= S_MEM;
            end
            CLS_STORE: begin
              mem_wr_q <= 1'b1;
              state    <= S_MEM;
            end
            CLS_JMP: begin
              pc    <= PC_WIDTH'(ir[IMM_MSB:IMM_LSB]);
              req_q <= 1'b1;
              state <= S_FETCH;
            end
            CLS_HALT: begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end
            default: begin
              req_q <= 1'b1;
              state <= S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          if (bus.mem_ready) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (dec_cls == CLS_LOAD) begin
              reg_we_q <= 1'b1;
              state    <= S_WB;
            end else begin
              req_q <= 1'b1;
              state <= S_FETCH;
            end
          end
        end

        S_WB: begin
          reg_we_q <= 1'b0;
          req_q    <= 1'b1;
          state    <= S_FETCH;
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          reg_we_q <= 1'b0;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          halted_q <= 1'b0;
          req_q    <= 1'b1;
          state    <= S_FETCH;
        end
      endcase
    end
  end

  // Output drive: registered values, fetch request masked while in reset.
  always_comb begin
    bus.instr_req  = req_q & ~rst;
    bus.instr_addr = pc;
    bus.op_code    = op_code_q;
    bus.imm_en     = imm_en_q;
    bus.imm_out    = imm_q;
    bus.rd_addr    = rd_q;
    bus.rs1_addr   = rs1_q;
    bus.rs2_addr   = rs2_q;
    bus.reg_we     = reg_we_q;
    bus.mem_rd     = mem_rd_q;
    bus.mem_wr     = mem_wr_q;
    bus.halted     = halted_q;
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Testbench for ctrl_fsm: table of instructions with expected decode,
// latency and strobe counts, checked through a scoreboard queue, plus
// hand-written HALT and reset-during-MEM sequences.
module tb_ctrl_fsm;

  logic clk = 1'b0;
  logic rst;

  ctrl_fsm_if #(.PC_WIDTH(8), .DATA_WIDTH(16)) bus ();

  ctrl_fsm #(.PC_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          fwait;
    int          mwait;
    logic [3:0]  op;
    logic        imm_en;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    int          cycles;
    int          we_cnt;
    int          we_cyc;
    int          rd_cnt;
    int          wr_cnt;
    logic [7:0]  next_pc;
    logic        halted;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] instr, input int fw, input int mw,
                              input int cyc, input int wec, input int wecyc,
                              input int rdc, input int wrc, input logic [7:0] npc,
                              input logic h);
    vec_t v;
    v.instr   = instr;
    v.fwait   = fw;
    v.mwait   = mw;
    v.op      = instr[15:12];
    v.imm_en  = (instr[15:12] == 4'd8);
    v.imm     = {8'h00, instr[7:0]};
    v.rd      = instr[11:8];
    v.rs1     = instr[7:4];
    v.rs2     = instr[3:0];
    v.cycles  = cyc;
    v.we_cnt  = wec;
    v.we_cyc  = wecyc;
    v.rd_cnt  = rdc;
    v.wr_cnt  = wrc;
    v.next_pc = npc;
    v.halted  = h;
    return v;
  endfunction

  // Run one instruction; must be entered during the low phase of its first
  // FETCH cycle. Returns at the low phase of the following FETCH (or HALT).
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int cyc = 0, fc = 0, mc = 0;
    int we_cnt = 0, we_cyc = 0, rd_cnt = 0, wr_cnt = 0;
    logic left = 1'b0, done = 1'b0, wb_imm_en = 1'b0;
    sb.push_back(v);
    for (int k = 0; k < 60 && !done; k++) begin
      if (left && (bus.instr_req || bus.halted)) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (!bus.instr_req) left = 1'b1;
        if (bus.reg_we) begin
          we_cnt++;
          we_cyc = cyc;
          wb_imm_en = bus.imm_en;
        end
        if (bus.mem_rd) rd_cnt++;
        if (bus.mem_wr) wr_cnt++;
        if (bus.instr_req) begin
          bus.instr_data  = v.instr;
          bus.instr_valid = (fc >= v.fwait);
          fc++;
        end else begin
          bus.instr_data  = 16'hF000;
          bus.instr_valid = 1'b1;
        end
        if (bus.mem_rd || bus.mem_wr) begin
          bus.mem_ready = (mc >= v.mwait);
          mc++;
        end else begin
          bus.mem_ready = 1'b1;
        end
        @(negedge clk);
      end
    end
    e = sb.pop_front();
    chk($sformatf("v%0d_done", idx), done, 1'b1);
    chk($sformatf("v%0d_op", idx), bus.op_code, e.op);
    chk($sformatf("v%0d_imm_en", idx), bus.imm_en, e.imm_en);
    chk($sformatf("v%0d_imm", idx), bus.imm_out, e.imm);
    chk($sformatf("v%0d_rd", idx), bus.rd_addr, e.rd);
    chk($sformatf("v%0d_rs1", idx), bus.rs1_addr, e.rs1);
    chk($sformatf("v%0d_rs2", idx), bus.rs2_addr, e.rs2);
    chk($sformatf("v%0d_cycles", idx), cyc, e.cycles);
    chk($sformatf("v%0d_we_cnt", idx), we_cnt, e.we_cnt);
    chk($sformatf("v%0d_we_cyc", idx), we_cyc, e.we_cyc);
    chk($sformatf("v%0d_rd_cnt", idx), rd_cnt, e.rd_cnt);
    chk($sformatf("v%0d_wr_cnt", idx), wr_cnt, e.wr_cnt);
    chk($sformatf("v%0d_wb_imm_en", idx), wb_imm_en, e.imm_en && (e.we_cnt > 0));
    chk($sformatf("v%0d_next_pc", idx), bus.instr_addr, e.next_pc);
    chk($sformatf("v%0d_halted", idx), bus.halted, e.halted);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic seen;

    //          instr     fw mw cyc we wecyc rd wr next_pc halted
    vecs.push_back(mk(16'h1234, 0, 0, 4, 1, 4, 0, 0, 8'h01, 1'b0)); // ALU
    vecs.push_back(mk(16'h85A7, 0, 0, 4, 1, 4, 0, 0, 8'h02, 1'b0)); // LDI
    vecs.push_back(mk(16'h9310, 0, 3, 8, 1, 8, 4, 0, 8'h03, 1'b0)); // LOAD, 3 waits
    vecs.push_back(mk(16'hA012, 2, 0, 6, 0, 0, 0, 1, 8'h04, 1'b0)); // STORE, 2 fetch waits
    vecs.push_back(mk(16'hC0F0, 0, 0, 3, 0, 0, 0, 0, 8'hF0, 1'b0)); // JMP
    vecs.push_back(mk(16'hB123, 0, 0, 3, 0, 0, 0, 0, 8'hF1, 1'b0)); // NOP
    vecs.push_back(mk(16'h7ABC, 1, 0, 5, 1, 5, 0, 0, 8'hF2, 1'b0)); // ALU, 1 fetch wait
    vecs.push_back(mk(16'hC0FF, 0, 0, 3, 0, 0, 0, 0, 8'hFF, 1'b0)); // JMP to last address
    vecs.push_back(mk(16'h0000, 0, 0, 4, 1, 4, 0, 0, 8'h00, 1'b0)); // ALU, pc wraps
    vecs.push_back(mk(16'hA345, 0, 1, 5, 0, 0, 0, 2, 8'h01, 1'b0)); // STORE, 1 wait
    vecs.push_back(mk(16'hF000, 0, 0, 3, 0, 0, 0, 0, 8'h02, 1'b1)); // HALT

    rst = 1'b1;
    bus.instr_data  = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_req", bus.instr_req, 1'b0);
    chk("rst_pc", bus.instr_addr, 8'h00);
    chk("rst_decoded", {bus.op_code, bus.imm_en, bus.imm_out, bus.rd_addr,
                        bus.rs1_addr, bus.rs2_addr}, 32'h0);
    chk("rst_strobes", {bus.reg_we, bus.mem_rd, bus.mem_wr, bus.halted}, 4'h0);
    rst = 1'b0;
    #1;
    chk("rel_instr_req", bus.instr_req, 1'b1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // HALT must absorb whatever arrives on the inputs.
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      bus.instr_valid = 1'b1;
      bus.mem_ready   = 1'($urandom_range(0, 1));
      bus.instr_data  = 16'h1234;
      @(negedge clk);
      if (!(bus.halted === 1'b1 && bus.instr_req === 1'b0 &&
            bus.reg_we === 1'b0 && bus.mem_rd === 1'b0 && bus.mem_wr === 1'b0)) bad++;
    end
    chk("halt_hold_bad_cycles", bad, 0);

    rst = 1'b1;
    @(negedge clk);
    chk("halt_rst_halted", bus.halted, 1'b0);
    rst = 1'b0;
    #1;
    chk("halt_rel_instr_req", bus.instr_req, 1'b1);
    chk("halt_rel_addr", bus.instr_addr, 8'h00);

    // Reset while a LOAD is stalled in MEM.
    bus.instr_data  = 16'h9310;
    bus.instr_valid = 1'b1;
    bus.mem_ready   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_rd) seen = 1'b1;
      if (!bus.instr_req) bus.instr_valid = 1'b0;
    end
    chk("mem_rst_reached_mem", seen, 1'b1);
    chk("mem_rst_pc_before", bus.instr_addr, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    chk("mem_rst_strobes", {bus.reg_we, bus.mem_rd, bus.mem_wr, bus.halted, bus.instr_req}, 5'h0);
    chk("mem_rst_pc", bus.instr_addr, 8'h00);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("mem_rst_rel_req", bus.instr_req, 1'b1);

    run_vec(99, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
